// File: rtl/if_instr_queue_if.sv
// Fetch/decode handshake bundle for if_instr_queue.
// slave is the queue's view; master is the IF/ID/EXE side that drives it.
interface if_instr_queue_if #(
  parameter int unsigned PC_W    = 32,
  parameter int unsigned INSTR_W = 32
);
  logic               if_valid;
  logic [PC_W-1:0]    PC;
  logic [INSTR_W-1:0] Instruction;
  logic               freeze;
  logic               Branch_taken;
  logic               id_ready;
  logic               id_valid;
  logic [PC_W-1:0]    id_PC;
  logic [INSTR_W-1:0] id_Instruction;

  modport master (
    output if_valid, PC, Instruction, Branch_taken, id_ready,
    input  freeze, id_valid, id_PC, id_Instruction
  );

  modport slave (
    input  if_valid, PC, Instruction, Branch_taken, id_ready,
    output freeze, id_valid, id_PC, id_Instruction
  );
endinterface

// File: rtl/if_instr_queue.sv
// Fetch-side instruction queue between IF and ID, with branch flush and full backpressure.
// Define IFQ_STATS_EN to add the saturating flush_count output.
module if_instr_queue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  if_instr_queue_if.slave    bus
`ifdef IFQ_STATS_EN
  ,
  output logic [15:0]        flush_count
`endif
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);

  logic [PC_W-1:0]    mem_pc    [DEPTH];
  logic [INSTR_W-1:0] mem_instr [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        count;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;

  always_comb begin
    full  = (count == FULL_LVL);
    empty = (count == '0);
    push  = bus.if_valid & ~full & ~bus.Branch_taken;
    pop   = ~empty & bus.id_ready & ~bus.Branch_taken;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.Branch_taken) begin
      // Flush: discard everything in flight by snapping the read side onto the write side.
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]    <= bus.PC;
      mem_instr[wr_ptr] <= bus.Instruction;
    end
  end

  // Head is presented straight from storage; no write-to-read bypass.
  always_comb begin
    bus.id_valid       = ~empty;
    bus.freeze         = full;
    bus.id_PC          = '0;
    bus.id_Instruction = '0;
    if (!empty) begin
      bus.id_PC          = mem_pc[rd_ptr];
      bus.id_Instruction = mem_instr[rd_ptr];
    end
  end

`ifdef IFQ_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_count <= '0;
    end else if (bus.Branch_taken && !empty && (flush_count != '1)) begin
      flush_count <= flush_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_instr_queue.sv
// Randomized and directed bench for if_instr_queue against a queue-based reference model.
module tb_if_instr_queue;
  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  if_instr_queue_if #(.PC_W(32), .INSTR_W(32)) bus ();
`ifdef IFQ_STATS_EN
  logic [15:0] flush_count;
`endif

  if_instr_queue #(.DEPTH(DEPTH), .PC_W(32), .INSTR_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef IFQ_STATS_EN
    ,
    .flush_count(flush_count)
`endif
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  ent_t        mq[$];
  int unsigned m_flushes = 0;

  function automatic logic [31:0] exp_pc();
    return (mq.size() != 0) ? mq[0].pc : 32'h0;
  endfunction

  function automatic logic [31:0] exp_instr();
    return (mq.size() != 0) ? mq[0].instr : 32'h0;
  endfunction

  // Advance one clock edge and apply the queue rules to the model, then settle.
  task automatic step();
    ent_t e;
    bit   was_full;
    bit   do_pop;
    @(posedge clk);
    if (bus.Branch_taken) begin
      if (mq.size() != 0 && m_flushes < 65535) m_flushes++;
      mq.delete();
    end else begin
      was_full = (mq.size() == DEPTH);
      do_pop   = (mq.size() != 0) && bus.id_ready;
      e.pc     = bus.PC;
      e.instr  = bus.Instruction;
      if (do_pop) void'(mq.pop_front());
      if (bus.if_valid && !was_full) mq.push_back(e);
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic bt);
    bus.if_valid     = v;
    bus.PC           = pc;
    bus.Instruction  = $urandom;
    bus.id_ready     = rdy;
    bus.Branch_taken = bt;
  endtask

  task automatic test_reset();
    drive(1'b1, 32'h100, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      #2;
      n_checks++;
      if (bus.id_valid !== 1'b0 || bus.id_Instruction !== 32'h0 || bus.freeze !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold t=%0t valid=%b instr=%h freeze=%b required 0/0/0",
                 $time, bus.id_valid, bus.id_Instruction, bus.freeze);
      end
    end
`ifdef IFQ_STATS_EN
    n_checks++;
    if (flush_count !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_flush_count got=%0d required=0", flush_count);
    end
`endif
    #1 rst = 1'b1;
    mq.delete();
    step();
    n_checks++;
    if (bus.id_valid !== 1'b1 || bus.id_PC !== 32'h100 || bus.id_Instruction !== exp_instr()) begin
      n_fail++;
      $display("FAIL reset_first_fetch valid=%b pc=%h instr=%h required 1/00000100/%h",
               bus.id_valid, bus.id_PC, bus.id_Instruction, exp_instr());
    end
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    step();
    bus.Branch_taken = 1'b0;
  endtask

  task automatic test_stream();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'(4 * i), 1'b1, 1'b0);
      step();
      n_checks++;
      if (bus.id_valid !== 1'b1 || bus.id_PC !== 32'(4 * i) || bus.freeze !== 1'b0 ||
          bus.id_Instruction !== exp_instr()) begin
        n_fail++;
        $display("FAIL stream[%0d] valid=%b pc=%h freeze=%b instr=%h required 1/%h/0/%h",
                 i, bus.id_valid, bus.id_PC, bus.freeze, bus.id_Instruction, 32'(4 * i), exp_instr());
      end
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    step();
    n_checks++;
    if (bus.id_valid !== 1'b0 || bus.id_Instruction !== 32'h0) begin
      n_fail++;
      $display("FAIL stream_drain valid=%b instr=%h required 0/0", bus.id_valid, bus.id_Instruction);
    end
  endtask

  task automatic test_fill();
    logic [31:0] held_instr;
    logic [31:0] exp_seq [3];
    exp_seq[0] = 32'd8; exp_seq[1] = 32'd12; exp_seq[2] = 32'd16;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(4 * i), 1'b0, 1'b0);
      step();
      n_checks++;
      if (bus.freeze !== (i == 3) || bus.id_PC !== 32'h0) begin
        n_fail++;
        $display("FAIL fill_push[%0d] freeze=%b pc=%h required %b/0", i, bus.freeze, bus.id_PC, i == 3);
      end
    end
    drive(1'b1, 32'd16, 1'b0, 1'b0);
    held_instr = bus.Instruction;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (bus.freeze !== 1'b1 || bus.id_PC !== 32'h0) begin
        n_fail++;
        $display("FAIL fill_hold[%0d] freeze=%b pc=%h required 1/0", i, bus.freeze, bus.id_PC);
      end
    end
    bus.id_ready = 1'b1;
    step();
    n_checks++;
    if (bus.freeze !== 1'b0 || bus.id_PC !== 32'd4) begin
      n_fail++;
      $display("FAIL fill_pop freeze=%b pc=%h required 0/4", bus.freeze, bus.id_PC);
    end
    bus.id_ready = 1'b0;
    step();
    n_checks++;
    if (bus.freeze !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_refill freeze=%b required 1", bus.freeze);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (bus.id_valid !== 1'b1 || bus.id_PC !== exp_seq[i] ||
          (i == 2 && bus.id_Instruction !== held_instr)) begin
        n_fail++;
        $display("FAIL fill_drain[%0d] valid=%b pc=%h instr=%h required 1/%h", i, bus.id_valid,
                 bus.id_PC, bus.id_Instruction, exp_seq[i]);
      end
    end
    step();
    n_checks++;
    if (bus.id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_empty valid=%b required 0", bus.id_valid);
    end
  endtask

  task automatic test_flush();
    int unsigned flushes_before;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(100 + 4 * i), 1'b0, 1'b0);
      step();
    end
    flushes_before = m_flushes;
    drive(1'b1, 32'd20, 1'b0, 1'b1);
    step();
    n_checks++;
    if (bus.id_valid !== 1'b0 || bus.id_Instruction !== 32'h0 || bus.freeze !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_empty valid=%b instr=%h freeze=%b required 0/0/0",
               bus.id_valid, bus.id_Instruction, bus.freeze);
    end
`ifdef IFQ_STATS_EN
    n_checks++;
    if (flush_count !== 16'(flushes_before + 1)) begin
      n_fail++;
      $display("FAIL flush_count got=%0d required=%0d", flush_count, flushes_before + 1);
    end
`endif
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (bus.id_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_held[%0d] valid=%b required 0", i, bus.id_valid);
      end
    end
`ifdef IFQ_STATS_EN
    n_checks++;
    if (flush_count !== 16'(flushes_before + 1)) begin
      n_fail++;
      $display("FAIL flush_count_empty got=%0d required=%0d", flush_count, flushes_before + 1);
    end
`endif
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(200 + 4 * i), 1'b0, 1'b0);
      step();
    end
    bus.Branch_taken = 1'b1;
    step();
    n_checks++;
    if (bus.freeze !== 1'b0 || bus.id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_full freeze=%b valid=%b required 0/0", bus.freeze, bus.id_valid);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    step();
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'(4 * i), 1'b1, 1'b0);
      step();
      n_checks++;
      if (bus.id_valid !== 1'b1 || bus.id_PC !== 32'(4 * i) || bus.id_Instruction !== exp_instr()) begin
        n_fail++;
        $display("FAIL wrap[%0d] valid=%b pc=%h instr=%h required 1/%h/%h",
                 i, bus.id_valid, bus.id_PC, bus.id_Instruction, 32'(4 * i), exp_instr());
      end
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    step();
  endtask

  task automatic test_random();
    logic [31:0] next_pc = 32'h1000;
    for (int i = 0; i < 400; i++) begin
      if (!(bus.freeze === 1'b1 && bus.if_valid === 1'b1)) begin
        bus.if_valid    = ($urandom_range(3) != 0);
        bus.PC          = next_pc;
        bus.Instruction = $urandom;
        next_pc         = next_pc + 32'd4;
      end
      bus.id_ready     = $urandom_range(1);
      bus.Branch_taken = ($urandom_range(15) == 0);
      step();
      n_checks++;
      if (bus.id_valid !== (mq.size() != 0) || bus.id_PC !== exp_pc() ||
          bus.id_Instruction !== exp_instr() || bus.freeze !== (mq.size() == DEPTH)) begin
        n_fail++;
        $display("FAIL random[%0d] valid=%b pc=%h instr=%h freeze=%b required %b/%h/%h/%b", i,
                 bus.id_valid, bus.id_PC, bus.id_Instruction, bus.freeze,
                 mq.size() != 0, exp_pc(), exp_instr(), mq.size() == DEPTH);
      end
`ifdef IFQ_STATS_EN
      n_checks++;
      if (flush_count !== 16'(m_flushes)) begin
        n_fail++;
        $display("FAIL random_flush_count[%0d] got=%0d required=%0d", i, flush_count, m_flushes);
      end
`endif
    end
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    step();
  endtask

  task automatic test_async_reset();
    drive(1'b1, 32'h300, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      bus.PC = 32'(32'h300 + 4 * mq.size());
      step();
    end
    n_checks++;
    if (bus.freeze !== 1'b1) begin
      n_fail++;
      $display("FAIL async_prefill freeze=%b required 1", bus.freeze);
    end
    #3 rst = 1'b0;
    #1;
    n_checks++;
    if (bus.freeze !== 1'b0 || bus.id_valid !== 1'b0 || bus.id_Instruction !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset freeze=%b valid=%b instr=%h required 0/0/0",
               bus.freeze, bus.id_valid, bus.id_Instruction);
    end
`ifdef IFQ_STATS_EN
    n_checks++;
    if (flush_count !== 16'h0) begin
      n_fail++;
      $display("FAIL async_flush_count got=%0d required=0", flush_count);
    end
`endif
    mq.delete();
    m_flushes = 0;
    #2 rst = 1'b1;
    bus.PC = 32'h400;
    step();
    n_checks++;
    if (bus.id_valid !== 1'b1 || bus.id_PC !== 32'h400 || bus.freeze !== 1'b0) begin
      n_fail++;
      $display("FAIL async_recover valid=%b pc=%h freeze=%b required 1/400/0",
               bus.id_valid, bus.id_PC, bus.freeze);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_fill();
    test_flush();
    test_wrap();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
